// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle multiply / divide unit for the execute stage.
// Multiplies take a single MUL cycle. Divides use a restoring divider
// that produces one quotient bit per cycle.
// Optional feature: define EX_MULDIV_MADD_EN to enable MADD/MSUB
// (accumulate into forwarded HI/LO). Without it, op codes 4 and 5
// are treated as reserved.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | waiting for start_i with a legal op
// MUL      | one cycle: product (plus/minus accumulator) -> hi/lo
// DIV_ON   | WIDTH restoring-divide iterations over magnitudes
// DIV_ZERO | one cycle: divisor was zero, result forced to 0
// DONE     | result held; ready rises and holds while start_i stays high
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             ready_o,
    output logic             whilo_o,
    output logic             stallreq_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
`ifdef EX_MULDIV_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;
`endif

    typedef enum logic [2:0] {IDLE, MUL, DIV_ON, DIV_ZERO, DONE} state_t;

    state_t             state, state_nx;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   quo_q, rem_q, dvs_q;
    logic [CW-1:0]      cnt_q;
    logic               ready_q;

    logic               op_legal, op_is_div, accept;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res;
    logic [WIDTH:0]     partial, diff;
    logic               ge;
    logic [WIDTH-1:0]   quo_nx, rem_nx, q_fix, r_fix;
    logic               neg_q, neg_r;

`ifdef EX_MULDIV_MADD_EN
    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q;
    assign op_legal = (op_i <= OP_MSUB);
`else
    logic               unused_acc;
    assign unused_acc = ^{hi_i, lo_i};
    assign op_legal   = (op_i <= OP_DIVU);
`endif

    assign op_is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign accept    = (state == IDLE) && start_i && !annul_i && op_legal;

    // Only DIV works on magnitudes; DIVU takes operands as-is.
    assign a_abs = ((op_i == OP_DIV) && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign b_abs = ((op_i == OP_DIV) && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Multiply: sign-extending to 2*WIDTH gives the signed product modulo 2^(2*WIDTH).
    always_comb begin
        a_ext   = (op_q == OP_MULTU) ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
        b_ext   = (op_q == OP_MULTU) ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod    = a_ext * b_ext;
        mul_res = prod;
`ifdef EX_MULDIV_MADD_EN
        if (op_q == OP_MADD) mul_res = {acc_hi_q, acc_lo_q} + prod;
        if (op_q == OP_MSUB) mul_res = {acc_hi_q, acc_lo_q} - prod;
`endif
    end

    // One restoring step. rem_q < dvs_q always holds, so diff[WIDTH] is a clean borrow.
    always_comb begin
        partial = {rem_q, quo_q[WIDTH-1]};
        diff    = partial - {1'b0, dvs_q};
        ge      = ~diff[WIDTH];
        rem_nx  = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        quo_nx  = {quo_q[WIDTH-2:0], ge};
        neg_q   = (op_q == OP_DIV) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_r   = (op_q == OP_DIV) && a_q[WIDTH-1];
        q_fix   = neg_q ? -quo_nx : quo_nx;
        r_fix   = neg_r ? -rem_nx : rem_nx;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; annul aborts any busy state and wins over start in DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!op_is_div)             state_nx = MUL;
                    else if (opdata2_i == '0)   state_nx = DIV_ZERO;
                    else                        state_nx = DIV_ON;
                end
            end
            MUL, DIV_ZERO: state_nx = annul_i ? IDLE : DONE;
            DIV_ON: begin
                if (annul_i)                 state_nx = IDLE;
                else if (cnt_q == LAST_ITER) state_nx = DONE;
            end
            DONE: begin
                if (annul_i || !start_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, divider iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
`ifdef EX_MULDIV_MADD_EN
            acc_hi_q <= '0;
            acc_lo_q <= '0;
`endif
        end else begin
            ready_q <= (state == DONE) && start_i && !annul_i;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op_i;
                        a_q   <= opdata1_i;
                        b_q   <= opdata2_i;
                        quo_q <= a_abs;
                        dvs_q <= b_abs;
                        rem_q <= '0;
                        cnt_q <= '0;
`ifdef EX_MULDIV_MADD_EN
                        acc_hi_q <= hi_i;
                        acc_lo_q <= lo_i;
`endif
                    end
                end
                MUL: begin
                    if (!annul_i) {hi_o, lo_o} <= mul_res;
                end
                DIV_ZERO: begin
                    if (!annul_i) begin
                        hi_o <= '0;
                        lo_o <= '0;
                    end
                end
                DIV_ON: begin
                    if (!annul_i) begin
                        quo_q <= quo_nx;
                        rem_q <= rem_nx;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_ITER) begin
                            lo_o <= q_fix;
                            hi_o <= r_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ready_q is gated by start_i so ready drops in the same cycle start_i does.
    assign ready_o    = ready_q & start_i;
    assign whilo_o    = ready_o;
    assign stallreq_o = start_i & ~ready_o;

endmodule
